// File: rtl/jtkicker_objrom_slot.sv
`default_nettype none
// ============================================================================
// Module      : jtkicker_objrom_slot
// Description : Object-engine ROM responder. Each 32-bit request from the
//               sprite renderer is served by two 16-bit SDRAM reads
//               (low word, then high word) which are assembled into
//               rom_data = {hi16, lo16}. rom_ok is gated combinationally on
//               the address compare, so it can never qualify data that
//               belongs to an older address.
// Ports       : clk, rst (sync, active-high)
//               rom_cs / rom_addr[AW-1:0] -> rom_data[31:0] / rom_ok
//               sdram_addr[21:0] / sdram_req -> sdram_ack / sdram_rdy /
//               sdram_data[15:0]
// Options     : JTKICKER_OBJROM_CACHE_EN - keep the last fetched word valid
//               across rom_cs low periods, so a repeat request for the same
//               address is answered without an SDRAM access.
// Revision    : 1.0 - initial release
// ============================================================================
module jtkicker_objrom_slot #(
    parameter int          AW     = 13,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_cs,
    input  logic [AW-1:0] rom_addr,
    output logic [31:0]   rom_data,
    output logic          rom_ok,
    output logic [21:0]   sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [15:0]   sdram_data
);

`ifdef JTKICKER_OBJROM_CACHE_EN
    localparam bit c_keep_valid = 1'b1;
`else
    localparam bit c_keep_valid = 1'b0;
`endif

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_req_lo  = 3'd1;
    localparam logic [2:0] c_st_wait_lo = 3'd2;
    localparam logic [2:0] c_st_req_hi  = 3'd3;
    localparam logic [2:0] c_st_wait_hi = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [AW-1:0] r_lat_addr;
    logic          r_lat_valid;
    logic          r_stale;
    logic [15:0]   r_data_lo;
    logic [15:0]   r_data_hi;
    // ack and rdy arriving together: the data is parked here and consumed
    // in the first cycle of the following WAIT state.
    logic          r_rdy_early;
    logic [15:0]   r_early_data;

    logic          w_match;
    logic          w_stale;
    logic          w_start;
    logic          w_in_req;
    logic          w_rdy;
    logic [15:0]   w_rd_data;
    logic [AW:0]   w_pair_lo;
    logic [21:0]   w_word_lo;
    logic [21:0]   w_word_hi;

    assign w_match   = rom_cs && (rom_addr == r_lat_addr);
    assign rom_ok    = r_lat_valid && w_match;
    assign rom_data  = {r_data_hi, r_data_lo};
    // Sticky within a fetch: an address that changes away and back still
    // invalidates the transaction in flight.
    assign w_stale   = r_stale || !w_match;
    assign w_start   = rom_cs && !rom_ok;
    assign w_in_req  = (r_state == c_st_req_lo) || (r_state == c_st_req_hi);
    assign w_rdy     = sdram_rdy || r_rdy_early;
    assign w_rd_data = r_rdy_early ? r_early_data : sdram_data;

    // Zero-extend before the add so the sum wraps modulo 2^22.
    assign w_pair_lo = {r_lat_addr, 1'b0};
    assign w_word_lo = 22'(w_pair_lo);
    assign w_word_hi = w_word_lo | 22'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. An ack always wins over abandonment so the accepted
    // read is drained in WAIT before returning to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:    if (w_start) w_next = c_st_req_lo;
            c_st_req_lo:  if (sdram_ack) w_next = c_st_wait_lo;
                          else if (w_stale) w_next = c_st_idle;
            c_st_wait_lo: if (w_rdy) w_next = w_stale ? c_st_idle : c_st_req_hi;
            c_st_req_hi:  if (sdram_ack) w_next = c_st_wait_hi;
                          else if (w_stale) w_next = c_st_idle;
            c_st_wait_hi: if (w_rdy) w_next = c_st_idle;
            default:      w_next = c_st_idle;
        endcase
    end

    // Output logic
    always_comb begin
        sdram_req  = 1'b0;
        sdram_addr = 22'd0;
        case (r_state)
            c_st_req_lo: begin
                sdram_req  = 1'b1;
                sdram_addr = OFFSET + w_word_lo;
            end
            c_st_req_hi: begin
                sdram_req  = 1'b1;
                sdram_addr = OFFSET + w_word_hi;
            end
            default: ;
        endcase
    end

    // Datapath: latched address, validity, stale tracking and data words
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_addr   <= '0;
            r_lat_valid  <= 1'b0;
            r_stale      <= 1'b0;
            r_data_lo    <= 16'd0;
            r_data_hi    <= 16'd0;
            r_rdy_early  <= 1'b0;
            r_early_data <= 16'd0;
        end else begin
            r_rdy_early <= w_in_req && sdram_ack && sdram_rdy;
            if (w_in_req && sdram_ack) begin
                r_early_data <= sdram_data;
            end

            if (r_state == c_st_idle) begin
                r_stale <= 1'b0;
                if (w_start) begin
                    r_lat_addr  <= rom_addr;
                    r_lat_valid <= 1'b0;
                end else if (!rom_cs && !c_keep_valid) begin
                    r_lat_valid <= 1'b0;
                end
            end else if (!w_match) begin
                r_stale <= 1'b1;
            end

            if (r_state == c_st_wait_lo && w_rdy && !w_stale) begin
                r_data_lo <= w_rd_data;
            end

            if (r_state == c_st_wait_hi && w_rdy) begin
                if (!w_stale) begin
                    r_data_hi <= w_rd_data;
                end
                r_lat_valid <= !w_stale;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtkicker_objrom_slot.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtkicker_objrom_slot
// Description : Directed self-checking bench for jtkicker_objrom_slot. A
//               behavioural SDRAM controller answers the main instance
//               (OFFSET 22'h10000); a second instance (OFFSET 22'h3FFFFF) is
//               driven by hand to cover address wrap and coincident ack/rdy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtkicker_objrom_slot;

    localparam logic [21:0] c_offset = 22'h10000;

    logic        clk;
    logic        rst;
    logic        rom_cs;
    logic [12:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_data;

    logic        wr_cs;
    logic [12:0] wr_addr;
    logic [31:0] wr_rom_data;
    logic        wr_ok;
    logic [21:0] wr_sd_addr;
    logic        wr_req;
    logic        wr_ack;
    logic        wr_rdy;
    logic [15:0] wr_sd_data;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic        ack_en;
    logic        rdy_en;
    logic        pending;
    logic [21:0] acc_addr;
    int          ack_cnt;
    logic [21:0] addr_log[$];

    jtkicker_objrom_slot #(.AW(13), .OFFSET(c_offset)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_data (sdram_data)
    );

    jtkicker_objrom_slot #(.AW(13), .OFFSET(22'h3FFFFF)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .rom_cs     (wr_cs),
        .rom_addr   (wr_addr),
        .rom_data   (wr_rom_data),
        .rom_ok     (wr_ok),
        .sdram_addr (wr_sd_addr),
        .sdram_req  (wr_req),
        .sdram_ack  (wr_ack),
        .sdram_rdy  (wr_rdy),
        .sdram_data (wr_sd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem(input logic [21:0] a);
        case (a)
            22'h1014A: return 16'h1234;
            22'h1014B: return 16'hABCD;
            default:   return a[15:0] ^ 16'hC3C3;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [12:0] a);
        logic [21:0] lo;
        lo = c_offset + {8'd0, a, 1'b0};
        return {mem(lo + 22'd1), mem(lo)};
    endfunction

    // SDRAM controller model: ack on the negedge after req is seen, data on
    // the following negedge (zero-wait when both enables are set).
    initial begin
        sdram_ack  = 1'b0;
        sdram_rdy  = 1'b0;
        sdram_data = 16'd0;
        pending    = 1'b0;
        acc_addr   = 22'd0;
        ack_cnt    = 0;
        forever begin
            @(negedge clk);
            sdram_rdy = 1'b0;
            if (sdram_ack) begin
                sdram_ack = 1'b0;
                pending   = 1'b1;
            end
            if (pending && rdy_en) begin
                sdram_rdy  = 1'b1;
                sdram_data = mem(acc_addr);
                pending    = 1'b0;
            end else if (!pending && sdram_req && ack_en && !rst) begin
                sdram_ack = 1'b1;
                acc_addr  = sdram_addr;
                addr_log.push_back(sdram_addr);
                ack_cnt++;
            end
        end
    end

    // Whenever the main instance claims ok, its data must match its address.
    initial begin
        forever begin
            @(negedge clk);
            if (rom_ok) chk("ok_data", rom_data, exp_word(rom_addr));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target);
        int n;
        n = 0;
        while (ack_cnt < target && n < 50) begin
            step();
            n++;
        end
        if (ack_cnt < target) chk("ack_timeout", 32'(ack_cnt), 32'(target));
    endtask

    task automatic wait_ok();
        int n;
        n = 0;
        while (!rom_ok && n < 50) begin
            step();
            n++;
        end
        chk("ok_timeout", 32'(rom_ok), 32'd1);
    endtask

    initial begin
        int base;
        int lb;
        rst        = 1'b1;
        rom_cs     = 1'b0;
        rom_addr   = 13'd0;
        ack_en     = 1'b1;
        rdy_en     = 1'b1;
        wr_cs      = 1'b0;
        wr_addr    = 13'd0;
        wr_ack     = 1'b0;
        wr_rdy     = 1'b0;
        wr_sd_data = 16'd0;
        repeat (3) step();

        // Reset state
        chk("rst_ok",   32'(rom_ok),     32'd0);
        chk("rst_data", rom_data,        32'd0);
        chk("rst_req",  32'(sdram_req),  32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        rst = 1'b0;
        step();

        // Basic fetch of 0A5
        rom_cs   = 1'b1;
        rom_addr = 13'h0A5;
        step();
        chk("basic_req",   32'(sdram_req),  32'd1);
        chk("basic_addr0", 32'(sdram_addr), 32'h1014A);
        repeat (3) step();
        chk("basic_ok_c4", 32'(rom_ok), 32'd0);
        step();
        chk("basic_ok_c5", 32'(rom_ok), 32'd1);
        chk("basic_data",  rom_data,    32'hABCD1234);
        chk("basic_nlog",  32'(addr_log.size()), 32'd2);
        chk("basic_log0",  32'(addr_log[0]), 32'h1014A);
        chk("basic_log1",  32'(addr_log[1]), 32'h1014B);
        repeat (3) step();
        chk("hold_ok",  32'(rom_ok),    32'd1);
        chk("hold_req", 32'(sdram_req), 32'd0);

        // Cache behaviour: drop rom_cs for 4 cycles, then repeat 0A5
        rom_cs = 1'b0;
        step();
        chk("cs_low_ok", 32'(rom_ok), 32'd0);
        repeat (3) step();
        base     = ack_cnt;
        rom_cs   = 1'b1;
        rom_addr = 13'h0A5;
        #1;
`ifdef JTKICKER_OBJROM_CACHE_EN
        chk("cache_hit",  32'(rom_ok), 32'd1);
        repeat (6) step();
        chk("cache_nreq", 32'(ack_cnt - base), 32'd0);
        chk("cache_ok",   32'(rom_ok), 32'd1);
`else
        chk("cache_miss", 32'(rom_ok), 32'd0);
        repeat (5) step();
        chk("refetch_ok",   32'(rom_ok), 32'd1);
        chk("refetch_nreq", 32'(ack_cnt - base), 32'd2);
        chk("refetch_log0", 32'(addr_log[2]), 32'h1014A);
        chk("refetch_log1", 32'(addr_log[3]), 32'h1014B);
`endif
        chk("cache_data", rom_data, 32'hABCD1234);

        // Address change while WAIT_LO is outstanding
        rdy_en   = 1'b0;
        base     = ack_cnt;
        lb       = addr_log.size();
        rom_addr = 13'h010;
        wait_acks(base + 1);
        chk("mid_log0", 32'(addr_log[lb]), 32'h10020);
        rom_addr = 13'h0A6;
        rdy_en   = 1'b1;
        step();
        chk("mid_discard", rom_data,     32'hABCD1234);
        chk("mid_ok0",     32'(rom_ok),  32'd0);
        wait_ok();
        chk("mid_data",    rom_data,     32'hC28EC28F);
        chk("mid_log1",    32'(addr_log[lb + 1]), 32'h1014C);
        chk("mid_log2",    32'(addr_log[lb + 2]), 32'h1014D);

        // Abandon in REQ_LO before any ack
        base     = ack_cnt;
        ack_en   = 1'b0;
        rom_addr = 13'h123;
        repeat (10) step();
        chk("abn_req",  32'(sdram_req),  32'd1);
        chk("abn_addr", 32'(sdram_addr), 32'h10246);
        rom_cs = 1'b0;
        step();
        chk("abn_req_fall", 32'(sdram_req), 32'd0);
        chk("abn_ok",       32'(rom_ok),    32'd0);
        repeat (2) step();
        chk("abn_req_idle", 32'(sdram_req), 32'd0);
        chk("abn_nack",     32'(ack_cnt - base), 32'd0);
        ack_en = 1'b1;

        // Reset while WAIT_HI is outstanding
        rom_cs   = 1'b1;
        rom_addr = 13'h055;
        base     = ack_cnt;
        wait_acks(base + 2);
        rdy_en = 1'b0;
        rst    = 1'b1;
        rom_cs = 1'b0;
        step();
        chk("mrst_ok",   32'(rom_ok),     32'd0);
        chk("mrst_data", rom_data,        32'd0);
        chk("mrst_req",  32'(sdram_req),  32'd0);
        chk("mrst_addr", 32'(sdram_addr), 32'd0);
        rst    = 1'b0;
        rdy_en = 1'b1;
        step();
        chk("late_rdy_data", rom_data,       32'd0);
        chk("late_rdy_req",  32'(sdram_req), 32'd0);
        rom_cs = 1'b1;
        #1;
        chk("late_rdy_ok", 32'(rom_ok), 32'd0);
        rom_cs = 1'b0;
        step();

        // Wrap-around on the second instance, with ack+rdy together on hi
        wr_cs   = 1'b1;
        wr_addr = 13'd0;
        step();
        chk("wrap_req0",  32'(wr_req),     32'd1);
        chk("wrap_addr0", 32'(wr_sd_addr), 32'h3FFFFF);
        wr_ack = 1'b1;
        step();
        wr_ack     = 1'b0;
        wr_rdy     = 1'b1;
        wr_sd_data = 16'h1111;
        step();
        wr_rdy = 1'b0;
        chk("wrap_req1",  32'(wr_req),     32'd1);
        chk("wrap_addr1", 32'(wr_sd_addr), 32'h000000);
        wr_ack     = 1'b1;
        wr_rdy     = 1'b1;
        wr_sd_data = 16'h2222;
        step();
        wr_ack     = 1'b0;
        wr_rdy     = 1'b0;
        wr_sd_data = 16'h9999;
        chk("wrap_ok_wait", 32'(wr_ok), 32'd0);
        step();
        chk("wrap_ok",   32'(wr_ok),  32'd1);
        chk("wrap_data", wr_rom_data, 32'h22221111);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtkicker_objrom_slot.md
# jtkicker_objrom_slot

Responder for the object engine's 32-bit ROM request interface (`rom_cs`/`rom_addr`/`rom_data`/`rom_ok`). It answers each request by fetching two 16-bit words from the SDRAM controller and assembling them into one 32-bit word. `rom_ok` is guaranteed never to qualify data belonging to a stale address. It sits between the sprite renderer and the SDRAM bank arbiter.

## Interface

Parameters:

- `AW`, 13 — requester address width (32-bit word granularity).
- `OFFSET`, 22'h0 — 16-bit word offset of the object ROM region in SDRAM.

Ports:

- `clk` in 1 — system clock (48 MHz). Single clock domain. Reset is synchronous and active-high.
- `rst` in 1 — synchronous, active-high reset.
- `rom_cs` in 1 — request active.
- `rom_addr` in AW — requested 32-bit word address.
- `rom_data` out 32 — assembled data: `{hi16, lo16}`.
- `rom_ok` out 1 — `rom_data` is valid for the current `rom_addr`.
- `sdram_addr` out 22 — 16-bit word address.
- `sdram_req` out 1 — read request; held until acknowledged.
- `sdram_ack` in 1 — one-cycle pulse; the controller has accepted the request.
- `sdram_rdy` in 1 — one-cycle pulse; `sdram_data` is valid.
- `sdram_data` in 16 — read data.

## Operation

- Latched state: `lat_addr` (AW bits), `lat_valid`, `data_lo`, `data_hi`.
- `rom_ok = lat_valid & rom_cs & (rom_addr == lat_addr)`.
  - Combinational, so `rom_ok` drops in the same cycle that `rom_addr` changes.
- `rom_data = {data_hi, data_lo}`. It is registered and holds its last value when not ok.
- FSM states: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI.
  - IDLE:
    - If `rom_cs` is high and `rom_ok` is low: latch `lat_addr <= rom_addr`, clear `lat_valid`, go to REQ_LO.
  - REQ_LO:
    - Drive `sdram_req=1` and `sdram_addr = OFFSET + {lat_addr,1'b0}`.
    - On `sdram_ack`, go to WAIT_LO.
  - WAIT_LO:
    - `sdram_req=0`.
    - On `sdram_rdy`: `data_lo <= sdram_data`, go to REQ_HI.
  - REQ_HI:
    - Same as REQ_LO, but with address `OFFSET + {lat_addr,1'b1}`.
  - WAIT_HI:
    - On `sdram_rdy`: `data_hi <= sdram_data`.
    - Then: `lat_valid <= (rom_addr == lat_addr)`, go to IDLE.
- Address arithmetic:
  - `{lat_addr,1'b0}` is zero-extended to 22 bits before the add.
  - The sum wraps modulo 2^22.
- Address change mid-fetch:
  - Detected by `rom_addr != lat_addr` while in any non-IDLE state; sets a `stale` flag.
  - In REQ_* before the ack: abandon, deassert `sdram_req`, return to IDLE in the next cycle.
    - If `sdram_ack` and the abandonment coincide, treat the request as acked and follow the WAIT_* path below.
  - In WAIT_*: the accepted transaction must complete. Wait for `sdram_rdy`, discard the data (do not write `data_*`), return to IDLE.
  - IDLE then restarts with the new address.
- `rom_cs` dropping mid-fetch: the same as an address change. Finish any outstanding SDRAM read, then return to IDLE without setting `lat_valid`.
- `sdram_ack` and `sdram_rdy` in the same cycle: both are honoured (ack → WAIT, rdy captured in that WAIT).
- Only one SDRAM transaction is outstanding at any time.

## Timing

- Reset values:
  - `rom_ok=0`, `rom_data=0`, `sdram_req=0`, `sdram_addr=0`, state IDLE, `lat_valid=0`.
- `sdram_req` rises 1 cycle after a new request is seen in IDLE.
- Minimum latency from `rom_cs`/`rom_addr` to `rom_ok`, with zero-wait ack and rdy: 5 cycles.
- `rom_ok` stays high for as long as `rom_cs` and `rom_addr` are unchanged.
- The requester samples on a half-rate enable. This is safe because `rom_ok` is gated combinationally on the address compare.

## Configuration

- `JTKICKER_OBJROM_CACHE_EN` defined:
  - `lat_valid` is kept when `rom_cs` falls.
  - A later request for the same `lat_addr` gets `rom_ok` in the same cycle, with no SDRAM access.
- Not defined:
  - `lat_valid` is cleared whenever `rom_cs` is low.
  - Every assertion of `rom_cs` performs a full two-word fetch.

## Test plan

- **Basic fetch.** Reset, then `rom_cs=1`, `rom_addr=13'h0A5`, `OFFSET=22'h10000`, zero-wait controller.
  - `sdram_addr` must be 22'h1014A, then 22'h1014B.
  - With data 16'h1234 then 16'hABCD: `rom_data=32'hABCD1234`, `rom_ok=1` at cycle 5.
- **Address change mid-fetch.** Change `rom_addr` to 13'h0A6 while in WAIT_LO.
  - `rom_ok` must never assert for 13'h0A6 using 0A5 data.
  - The outstanding read completes and its data is discarded.
  - Next requests go to 22'h1014C and 22'h1014D.
- **Abandon before ack.** Hold `sdram_ack` low for 10 cycles in REQ_LO, then drop `rom_cs`.
  - `sdram_req` falls the next cycle.
  - No WAIT state is entered.
  - `rom_ok` stays 0.
- **Cache behaviour.** Repeat `rom_addr=13'h0A5` after dropping `rom_cs` for 4 cycles.
  - With `JTKICKER_OBJROM_CACHE_EN`: `rom_ok=1` in the first cycle and zero `sdram_req` pulses.
  - Without it: a new two-word fetch.
- **Wrap-around.** `OFFSET=22'h3FFFFF`, `rom_addr=0`.
  - `sdram_addr` must be 22'h3FFFFF, then 22'h000000.
- **Reset mid-operation.** Assert `rst` while in WAIT_HI.
  - All outputs return to reset values in the following cycle.
  - A later `sdram_rdy` pulse is ignored and `rom_ok` stays 0.
